// File: rtl/freq_bcd_conv.sv
// rtl/freq_bcd_conv.sv - sequential double-dabble converter from meter frequency to packed BCD
module freq_bcd_conv #(
  parameter int DATA_WIDTH = 9,
  parameter int DIGITS     = 3
) (
  input  logic                  ref_clk_i,
  input  logic                  rst_meas_clk,
  input  logic [DATA_WIDTH-1:0] freq_i,
  output logic [4*DIGITS-1:0]   bcd_o,
  output logic                  bcd_valid_o,
  input  logic                  bcd_ready_i,
  output logic                  busy_o
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam int CAT_W = 4 * DIGITS + DATA_WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    OUT   = 2'd2
  } state_t;

  state_t                state, state_next;
  logic [DATA_WIDTH-1:0] last_conv, last_conv_next;
  logic [DATA_WIDTH-1:0] bin_sr, bin_sr_next;
  logic [4*DIGITS-1:0]   bcd_acc, bcd_acc_next;
  logic [CNT_W-1:0]      bit_cnt, bit_cnt_next;
  logic [4*DIGITS-1:0]   bcd_next;
  logic                  valid_next;

  logic [4*DIGITS-1:0]   acc_adj;
  logic [CAT_W-1:0]      shifted;

  // One double-dabble iteration: add 3 to every digit >= 5, then shift the pair left
  always_comb begin
    acc_adj = bcd_acc;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd_acc[4*d +: 4] >= 4'd5) begin
        acc_adj[4*d +: 4] = bcd_acc[4*d +: 4] + 4'd3;
      end
    end
    shifted = {acc_adj, bin_sr} << 1;
  end

  // Next-state and datapath updates; only a value differing from the last capture starts work
  always_comb begin
    state_next     = state;
    last_conv_next = last_conv;
    bin_sr_next    = bin_sr;
    bcd_acc_next   = bcd_acc;
    bit_cnt_next   = bit_cnt;
    bcd_next       = bcd_o;
    valid_next     = bcd_valid_o;
    case (state)
      IDLE: begin
        if (freq_i != last_conv) begin
          last_conv_next = freq_i;
          bin_sr_next    = freq_i;
          bcd_acc_next   = '0;
          bit_cnt_next   = CNT_W'(DATA_WIDTH);
          state_next     = SHIFT;
        end
      end
      SHIFT: begin
        bcd_acc_next = shifted[CAT_W-1:DATA_WIDTH];
        bin_sr_next  = shifted[DATA_WIDTH-1:0];
        bit_cnt_next = bit_cnt - CNT_W'(1);
        if (bit_cnt == CNT_W'(1)) begin
          bcd_next   = shifted[CAT_W-1:DATA_WIDTH];
          valid_next = 1'b1;
          state_next = OUT;
        end
      end
      OUT: begin
        if (bcd_valid_o && bcd_ready_i) begin
          valid_next = 1'b0;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        valid_next = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset aborts any conversion in flight
  always_ff @(posedge ref_clk_i or posedge rst_meas_clk) begin
    if (rst_meas_clk) begin
      state       <= IDLE;
      last_conv   <= '0;
      bin_sr      <= '0;
      bcd_acc     <= '0;
      bit_cnt     <= '0;
      bcd_o       <= '0;
      bcd_valid_o <= 1'b0;
    end else begin
      state       <= state_next;
      last_conv   <= last_conv_next;
      bin_sr      <= bin_sr_next;
      bcd_acc     <= bcd_acc_next;
      bit_cnt     <= bit_cnt_next;
      bcd_o       <= bcd_next;
      bcd_valid_o <= valid_next;
    end
  end

  assign busy_o = (state != IDLE);

endmodule

// File: tb/tb_freq_bcd_conv.sv
// tb/tb_freq_bcd_conv.sv - directed and randomized bench for freq_bcd_conv
module tb_freq_bcd_conv;

  logic        clk = 1'b0;
  logic        rst;
  logic [8:0]  freq;
  logic [11:0] bcd;
  logic        valid;
  logic        ready;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int last_val = 0;

  freq_bcd_conv #(.DATA_WIDTH(9), .DIGITS(3)) dut (
    .ref_clk_i    (clk),
    .rst_meas_clk (rst),
    .freq_i       (freq),
    .bcd_o        (bcd),
    .bcd_valid_o  (valid),
    .bcd_ready_i  (ready),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Apply a new value with ready high and check exact latency, result and single-cycle valid
  task automatic convert(input int v, input string tag);
    freq  = 9'(v);
    ready = 1'b1;
    step();
    check({tag, "_busy_capture"}, 32'(busy), 32'd1);
    for (int i = 1; i < 9; i++) begin
      step();
      check({tag, "_valid_early"}, 32'(valid), 32'd0);
    end
    step();
    check({tag, "_valid"}, 32'(valid), 32'd1);
    check({tag, "_bcd"}, 32'(bcd), 32'(to_bcd(v)));
    step();
    check({tag, "_valid_drop"}, 32'(valid), 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
    last_val = v;
  endtask

  initial begin
    int v;
    rst   = 1'b1;
    freq  = '0;
    ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step();
      check("reset_valid", 32'(valid), 32'd0);
      check("reset_bcd", 32'(bcd), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
    end

    convert(123, "v123");
    convert(511, "v511");
    convert(500, "v500");
    convert(9, "v9");
    convert(10, "v10");
    convert(0, "v0");

    for (int n = 0; n < 10; n++) begin
      do v = int'($urandom_range(0, 511)); while (v == last_val);
      convert(v, "rand");
    end

    // Backpressure: 100 stalls in OUT while freq moves to 200 then 300
    freq  = 9'd100;
    ready = 1'b0;
    step();
    repeat (9) step();
    check("bp_valid", 32'(valid), 32'd1);
    check("bp_bcd", 32'(bcd), 32'h100);
    for (int i = 0; i < 30; i++) begin
      if (i == 5)  freq = 9'd200;
      if (i == 15) freq = 9'd300;
      step();
      check("bp_hold_valid", 32'(valid), 32'd1);
      check("bp_hold_bcd", 32'(bcd), 32'h100);
    end
    ready = 1'b1;
    step();
    check("bp_handshake_valid", 32'(valid), 32'd0);
    check("bp_handshake_idle", 32'(busy), 32'd0);
    step();
    check("bp_recapture", 32'(busy), 32'd1);
    for (int i = 1; i < 9; i++) begin
      step();
      check("bp_no_200", 32'(valid), 32'd0);
    end
    step();
    check("bp_300_valid", 32'(valid), 32'd1);
    check("bp_300_bcd", 32'(bcd), 32'h300);
    step();
    check("bp_300_drop", 32'(valid), 32'd0);
    last_val = 300;

    // Re-applying the last converted value must not start work
    freq = 9'd300;
    for (int i = 0; i < 20; i++) begin
      step();
      check("same_busy", 32'(busy), 32'd0);
      check("same_valid", 32'(valid), 32'd0);
    end

    // Reset four iterations into converting 255
    freq = 9'd255;
    step();
    repeat (4) step();
    check("abort_in_shift", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("abort_valid", 32'(valid), 32'd0);
    check("abort_bcd", 32'(bcd), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("abort_hold_valid", 32'(valid), 32'd0);
    rst = 1'b0;
    convert(255, "post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/freq_bcd_conv.md
# freq_bcd_conv

Converts the 9-bit binary frequency reading from the frequency meter into three packed BCD digits for the display/readout path. It sits directly downstream of the meter, in the reference-clock domain. It watches the meter's `freq_o` output and starts a sequential shift-add-3 (double-dabble) conversion whenever the value changes. Each result is delivered over a valid/ready handshake.

## Interface
- `DATA_WIDTH`, default 9: binary input width. Must satisfy 10^`DIGITS` > 2^`DATA_WIDTH` − 1.
- `DIGITS`, default 3: number of BCD digits produced.

- `ref_clk_i`, input, 1: reference clock. All logic runs in this domain.
- `rst_meas_clk`, input, 1: reset, asynchronous, active-high. The block is clocked by `ref_clk_i`.
- `freq_i`, input, `DATA_WIDTH`: binary frequency. Driven by the meter's `freq_o`, which is already synchronous to `ref_clk_i`.
- `bcd_o`, output, 4·`DIGITS`: packed BCD digits, most significant digit in the MSBs.
- `bcd_valid_o`, output, 1: `bcd_o` holds a new result.
- `bcd_ready_i`, input, 1: consumer accepts the result.
- `busy_o`, output, 1: high in SHIFT and OUT.

## Operation
- Internal registers:
  - `last_conv` (`DATA_WIDTH`): last captured value.
  - `bin_sr` (`DATA_WIDTH`): binary shift register.
  - `bcd_acc` (4·`DIGITS`): BCD accumulator.
  - `bit_cnt`: width $clog2(`DATA_WIDTH`+1).
- FSM states: IDLE, SHIFT, OUT.
- IDLE, when `freq_i` != `last_conv`:
  - `last_conv` <= `freq_i`; `bin_sr` <= `freq_i`; `bcd_acc` <= 0; `bit_cnt` <= `DATA_WIDTH`.
  - Next state: SHIFT.
- IDLE, when `freq_i` == `last_conv`: stay in IDLE, no action.
- SHIFT, one iteration per cycle:
  - Every digit of `bcd_acc` >= 5 gets +3 (4-bit add, no carry between digits).
  - Then {`bcd_acc`, `bin_sr`} shifts left by one bit.
  - `bit_cnt` decrements.
- SHIFT, on the iteration where `bit_cnt` == 1:
  - The post-shift accumulator is written to `bcd_o`.
  - `bcd_valid_o` <= 1.
  - Next state: OUT.
- OUT:
  - `bcd_o` and `bcd_valid_o` hold while `bcd_ready_i` = 0.
  - On `bcd_valid_o` & `bcd_ready_i` at a clock edge: `bcd_valid_o` <= 0, next state IDLE.
- `bcd_o` changes only on conversion completion. Between results it retains the last converted value.
- Changes of `freq_i` during SHIFT/OUT are not queued. On return to IDLE the current `freq_i` is compared with `last_conv`, so only the newest value is converted and intermediate values are dropped.
- Re-applying the value equal to `last_conv` never starts a conversion.
- `busy_o` = (state != IDLE), combinational from the state register.

## Timing
- Reset values:
  - State IDLE.
  - `bcd_o` = 0, `bcd_valid_o` = 0, `busy_o` = 0.
  - `last_conv` = 0, `bin_sr` = 0, `bcd_acc` = 0, `bit_cnt` = 0.
- Reset mid-operation (SHIFT or OUT): the conversion is aborted immediately. No valid pulse is produced, and all registers return to their reset values.
- After reset release with `freq_i` != 0: capture occurs on the first `ref_clk_i` edge.
- Latency:
  - `freq_i` new value is stable before edge k, and the FSM is in IDLE: capture at edge k.
  - Iterations run on edges k+1 .. k+`DATA_WIDTH`.
  - `bcd_valid_o` is high after edge k+`DATA_WIDTH` (9 cycles at default).
- With `bcd_ready_i` held high: the handshake completes at edge k+`DATA_WIDTH`+1. The earliest next capture is at edge k+`DATA_WIDTH`+2.
- Minimum conversion period is `DATA_WIDTH`+2 cycles. The meter updates once per second, so this never limits throughput in practice.
- `bcd_ready_i` may be high before `bcd_valid_o`. This is not a handshake; only the cycle with both high counts.
- No combinational path from `bcd_ready_i` to `bcd_valid_o`.

## Test plan
1. Reset held with `freq_i`=0, then released; observe 50 cycles -> `bcd_valid_o` stays 0, `bcd_o`=12'h000, `busy_o`=0.
2. `freq_i`=9'd123, `bcd_ready_i`=1 -> `bcd_valid_o` rises exactly 9 cycles after the capture edge with `bcd_o`=12'h123. Valid is high for one cycle, then the FSM returns to IDLE.
3. Boundary values applied in sequence:
   - 511 -> 12'h511
   - 500 -> 12'h500
   - 9 -> 12'h009
   - 10 -> 12'h010
   - 0 -> 12'h000 (a conversion does run, since the value differs from `last_conv`).
4. Backpressure:
   - Convert 100, then hold `bcd_ready_i`=0 for 30 cycles. `freq_i` changes to 200, then 300, during OUT.
   - Required while stalled: `bcd_o`=12'h100 and valid stays high.
   - After ready: exactly one further conversion, producing 12'h300. The value 200 is never output.
5. Re-apply the `freq_i` value equal to the last converted value (e.g. 300 after 300) -> no new `busy_o`, no valid pulse.
6. Assert `rst_meas_clk` 4 cycles into SHIFT while converting 255 -> `bcd_valid_o`=0 and `bcd_o`=0 immediately. After release with `freq_i`=255, the result 12'h255 arrives 9 cycles after the first post-reset edge.
